// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared widths and the buffered-store entry type
package store_buffer_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-3:0] word_addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;
endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: MEM-stage store/load request bus into the store buffer
interface store_buffer_if;
    import store_buffer_pkg::*;

    logic              store_valid;
    logic [ADDR_W-1:0] store_addr;
    logic [DATA_W-1:0] store_data;
    logic              store_ready;
    logic              load_valid;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_stall;

    modport master (
        output store_valid, store_addr, store_data, load_valid, load_addr,
        input  store_ready, load_data, load_stall
    );

    modport slave (
        input  store_valid, store_addr, store_data, load_valid, load_addr,
        output store_ready, load_data, load_stall
    );
endinterface

// File: rtl/store_buffer_match.sv
// store_buffer_match: finds the youngest live entry whose word address equals the load's
module store_buffer_match
    import store_buffer_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic      [DEPTH-1:0]  valid_i,
    input  sb_entry_t [DEPTH-1:0]  entries_i,
    input  logic      [PTR_W-1:0]  head_i,
    input  logic      [ADDR_W-3:0] addr_i,
    output logic      [DEPTH-1:0]  hit_oh_o,
    output logic                   hit_o,
    output logic      [DATA_W-1:0] hit_data_o
);
    logic [PTR_W-1:0] idx;

    // Scan oldest to youngest starting at head so a younger hit replaces any older one
    always_comb begin
        hit_oh_o   = '0;
        hit_data_o = '0;
        idx        = head_i;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + PTR_W'(k);
            if (valid_i[idx] && entries_i[idx].word_addr == addr_i) begin
                hit_oh_o      = '0;
                hit_oh_o[idx] = 1'b1;
                hit_data_o    = entries_i[idx].data;
            end
        end
    end

    assign hit_o = |hit_oh_o;
endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the MEM stage and the data memory.
// Define STORE_BUF_FORWARD_EN to forward buffered data to hitting loads;
// without it a hitting load stalls until the matching entries have drained.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    store_buffer_if.slave     bus,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    output logic              mem_read_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic      [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic      [PTR_W:0]    count_q, count_d;
    sb_entry_t [DEPTH-1:0]  entries_q;
    logic      [DEPTH-1:0]  valid, hit_oh;
    logic      [DATA_W-1:0] hit_data;
    logic                   hit, push, drain, port_free;
    logic                   unused_bits;

    // An entry is live when its distance from head is below the occupancy
    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++)
            valid[i] = {1'b0, PTR_W'(i) - head_q} < count_q;
    end

    store_buffer_match #(.DEPTH(DEPTH)) u_match (
        .valid_i    (valid),
        .entries_i  (entries_q),
        .head_i     (head_q),
        .addr_i     (bus.load_addr[ADDR_W-1:2]),
        .hit_oh_o   (hit_oh),
        .hit_o      (hit),
        .hit_data_o (hit_data)
    );

`ifdef STORE_BUF_FORWARD_EN
    assign bus.load_stall = 1'b0;
    assign bus.load_data  = hit ? hit_data : mem_rdata_i;
    assign port_free      = hit;
    assign unused_bits    = ^{hit_oh, bus.store_addr[1:0], bus.load_addr[1:0]};
`else
    assign bus.load_stall = bus.load_valid && hit;
    assign bus.load_data  = mem_rdata_i;
    assign port_free      = bus.load_stall;
    assign unused_bits    = ^{hit_oh, hit_data, bus.store_addr[1:0], bus.load_addr[1:0]};
`endif

    // A pending load owns the memory port unless it is stalled or served from the buffer
    assign bus.store_ready = (count_q != (PTR_W+1)'(DEPTH)) && !bus.load_valid;
    assign push            = bus.store_valid && bus.store_ready;
    assign drain           = (count_q != '0) && (!bus.load_valid || port_free);
    assign mem_we_o        = drain;
    assign mem_read_o      = !drain && bus.load_valid;
    assign mem_addr_o      = drain ? {entries_q[head_q].word_addr, 2'b00} : bus.load_valid ? bus.load_addr : '0;
    assign mem_wdata_o     = drain ? entries_q[head_q].data : '0;
    assign empty_o         = count_q == '0;

    // Pointers wrap naturally at DEPTH; a simultaneous push and drain leaves count unchanged
    always_comb begin
        head_d  = head_q + PTR_W'(drain);
        tail_d  = tail_q + PTR_W'(push);
        count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(drain);
    end

    // Reset discards every buffered store by emptying the pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payloads need no reset since liveness comes from the pointers
    always_ff @(posedge clk) begin
        if (push)
            entries_q[tail_q] <= '{word_addr: bus.store_addr[ADDR_W-1:2], data: bus.store_data};
    end

    a_store_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        bus.store_valid |-> bus.store_addr[1:0] == 2'b00)
        else $error("store_buffer: misaligned store address %h", bus.store_addr);

    a_load_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        bus.load_valid |-> bus.load_addr[1:0] == 2'b00)
        else $error("store_buffer: misaligned load address %h", bus.load_addr);
endmodule
